// File: rtl/chunk_packer_pkg.sv
// Shared widths and types for the 6x6-bit chunk packer that feeds the
// 36-bit parity reduction stage.
package chunk_packer_pkg;

    localparam int CHUNK_W    = 6;
    localparam int NUM_CHUNKS = 6;
    localparam int WORD_W     = CHUNK_W * NUM_CHUNKS;

    typedef logic [CHUNK_W-1:0] chunk_t;
    typedef logic [WORD_W-1:0]  word_t;
    typedef logic [2:0]         idx_t;

endpackage

// File: rtl/chunk_parity.sv
// Combinational XOR reduction of one input chunk, used to fold each accepted
// chunk into the running word parity.
module chunk_parity #(
    parameter int W = chunk_packer_pkg::CHUNK_W
) (
    input  logic [W-1:0] chunk,
    output logic         parity
);

    assign parity = ^chunk;

endmodule

// File: rtl/chunk_packer36.sv
// Packs 6-bit chunks LSB-first into a 36-bit word with incremental parity,
// a chunk count and a registered valid/ready output; IN_LAST flushes early.
module chunk_packer36 #(
    parameter int CHUNK_W    = 6,
    parameter int NUM_CHUNKS = 6,
    parameter int CNT_W      = 16
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic                          IN_VALID,
    output logic                          IN_READY,
    input  logic [CHUNK_W-1:0]            IN_DATA,
    input  logic                          IN_LAST,
    output logic                          OUT_VALID,
    input  logic                          OUT_READY,
    output logic [CHUNK_W*NUM_CHUNKS-1:0] OUT_DATA,
    output logic                          OUT_PARITY,
    output logic [2:0]                    OUT_COUNT,
    output logic [CNT_W-1:0]              WORD_CNT
);

    localparam int WORD_W = CHUNK_W * NUM_CHUNKS;

    import chunk_packer_pkg::idx_t;

    localparam idx_t LAST_IDX = idx_t'(NUM_CHUNKS - 1);

    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] merged;
    idx_t              idx;
    logic              run_par;
    logic              chunk_par;
    logic              accept;
    logic              complete;
    logic              handoff;

    chunk_parity #(.W(CHUNK_W)) u_chunk_parity (
        .chunk  (IN_DATA),
        .parity (chunk_par)
    );

    // The output slot frees up in the same cycle it is handed off.
    assign IN_READY = !OUT_VALID || OUT_READY;
    assign accept   = IN_VALID && IN_READY;
    assign complete = accept && ((idx == LAST_IDX) || IN_LAST);
    assign handoff  = OUT_VALID && OUT_READY;

    // Slots above idx are already zero because acc clears on every completion.
    always_comb begin
        // NOTE: assigning the default first keeps this block free of inferred latches.
        merged = acc;
        merged[CHUNK_W*int'(idx) +: CHUNK_W] = IN_DATA;
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            acc        <= '0;
            idx        <= '0;
            run_par    <= 1'b0;
            OUT_VALID  <= 1'b0;
            OUT_DATA   <= '0;
            OUT_PARITY <= 1'b0;
            OUT_COUNT  <= '0;
            WORD_CNT   <= '0;
        end else begin
            if (accept) begin
                if (complete) begin
                    OUT_DATA   <= merged;
                    OUT_PARITY <= run_par ^ chunk_par;
                    OUT_COUNT  <= idx + 3'd1;
                    acc        <= '0;
                    idx        <= '0;
                    run_par    <= 1'b0;
                end else begin
                    acc        <= merged;
                    idx        <= idx + 3'd1;
                    run_par    <= run_par ^ chunk_par;
                end
            end

            // A completion during hand-off reloads the slot and keeps it valid.
            if (complete) begin
                OUT_VALID <= 1'b1;
            end else if (OUT_READY) begin
                OUT_VALID <= 1'b0;
            end

            if (handoff) begin
                WORD_CNT <= WORD_CNT + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_chunk_packer36.sv
// Self-checking bench for chunk_packer36: directed scenarios plus a randomized
// stream checked against a queue-based word model.
module tb_chunk_packer36;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        IN_VALID = 1'b0;
    logic        IN_READY;
    logic [5:0]  IN_DATA = '0;
    logic        IN_LAST = 1'b0;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b0;
    logic [35:0] OUT_DATA;
    logic        OUT_PARITY;
    logic [2:0]  OUT_COUNT;
    logic [15:0] WORD_CNT;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [35:0] data;
        logic        par;
        logic [2:0]  cnt;
    } word_s;

    chunk_packer36 dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .IN_DATA    (IN_DATA),
        .IN_LAST    (IN_LAST),
        .OUT_VALID  (OUT_VALID),
        .OUT_READY  (OUT_READY),
        .OUT_DATA   (OUT_DATA),
        .OUT_PARITY (OUT_PARITY),
        .OUT_COUNT  (OUT_COUNT),
        .WORD_CNT   (WORD_CNT)
    );

    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        IN_VALID  = 1'b0;
        IN_LAST   = 1'b0;
        IN_DATA   = '0;
        OUT_READY = 1'b0;
        reset_n   = 1'b0;
        #1;
        repeat (2) cycle();
        reset_n = 1'b1;
    endtask

    // Offer one chunk and wait (bounded) until it is taken.
    task automatic send(input logic [5:0] d, input logic l);
        int waited = 0;
        IN_VALID = 1'b1;
        IN_DATA  = d;
        IN_LAST  = l;
        while (!IN_READY && waited < 50) begin
            cycle();
            waited++;
        end
        if (!IN_READY) begin
            errors++;
            $display("FAIL send_timeout: IN_READY got %b required 1", IN_READY);
        end
        cycle();
        IN_VALID = 1'b0;
        IN_LAST  = 1'b0;
    endtask

    task automatic test_reset();
        IN_VALID = 1'b0;
        reset_n  = 1'b0;
        #1;
        checks++;
        if ({OUT_VALID, OUT_PARITY, OUT_COUNT, OUT_DATA, WORD_CNT} !== 57'd0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b p=%b c=%0d d=%h w=%h required all 0",
                     OUT_VALID, OUT_PARITY, OUT_COUNT, OUT_DATA, WORD_CNT);
        end
        cycle();
        reset_n = 1'b1;
        cycle();
        checks++;
        if (IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b required 1", IN_READY);
        end
    endtask

    task automatic test_full_word();
        do_reset();
        OUT_READY = 1'b1;
        for (int k = 1; k <= 6; k++) send(6'(k), 1'b0);
        checks++;
        if ({OUT_VALID, OUT_PARITY, OUT_COUNT, OUT_DATA} !== {1'b1, 1'b1, 3'd6, 36'h185103081}) begin
            errors++;
            $display("FAIL full_word: got v=%b p=%b c=%0d d=%h required v=1 p=1 c=6 d=185103081",
                     OUT_VALID, OUT_PARITY, OUT_COUNT, OUT_DATA);
        end
        cycle();
        checks++;
        if ({OUT_VALID, WORD_CNT} !== {1'b0, 16'd1}) begin
            errors++;
            $display("FAIL full_word_cnt: got v=%b w=%0d required v=0 w=1", OUT_VALID, WORD_CNT);
        end
    endtask

    task automatic test_partial_flush();
        do_reset();
        OUT_READY = 1'b1;
        send(6'h3F, 1'b0);
        send(6'h3F, 1'b0);
        send(6'h01, 1'b1);
        checks++;
        if ({OUT_VALID, OUT_PARITY, OUT_COUNT, OUT_DATA} !== {1'b1, 1'b1, 3'd3, 36'h000001FFF}) begin
            errors++;
            $display("FAIL partial_flush: got v=%b p=%b c=%0d d=%h required v=1 p=1 c=3 d=000001fff",
                     OUT_VALID, OUT_PARITY, OUT_COUNT, OUT_DATA);
        end
    endtask

    task automatic test_single_chunk();
        do_reset();
        OUT_READY = 1'b1;
        send(6'h07, 1'b1);
        checks++;
        if ({OUT_VALID, OUT_PARITY, OUT_COUNT, OUT_DATA} !== {1'b1, 1'b1, 3'd1, 36'h7}) begin
            errors++;
            $display("FAIL single_chunk: got v=%b p=%b c=%0d d=%h required v=1 p=1 c=1 d=7",
                     OUT_VALID, OUT_PARITY, OUT_COUNT, OUT_DATA);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        OUT_READY = 1'b0;
        for (int k = 1; k <= 6; k++) send(6'(k), 1'b0);
        IN_VALID = 1'b1;
        IN_DATA  = 6'h2A;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({OUT_VALID, IN_READY, OUT_PARITY, OUT_COUNT, OUT_DATA} !==
                {1'b1, 1'b0, 1'b1, 3'd6, 36'h185103081}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b rdy=%b p=%b c=%0d d=%h required v=1 rdy=0 p=1 c=6 d=185103081",
                         i, OUT_VALID, IN_READY, OUT_PARITY, OUT_COUNT, OUT_DATA);
            end
            cycle();
        end
        OUT_READY = 1'b1;
        #1;
        checks++;
        if (IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b required 1", IN_READY);
        end
        cycle();
        IN_VALID = 1'b0;
        checks++;
        if ({OUT_VALID, WORD_CNT} !== {1'b0, 16'd1}) begin
            errors++;
            $display("FAIL bp_handoff: got v=%b w=%0d required v=0 w=1", OUT_VALID, WORD_CNT);
        end
        send(6'h15, 1'b1);
        checks++;
        if ({OUT_VALID, OUT_PARITY, OUT_COUNT, OUT_DATA} !== {1'b1, 1'b0, 3'd2, 36'h00000056A}) begin
            errors++;
            $display("FAIL bp_slot0: got v=%b p=%b c=%0d d=%h required v=1 p=0 c=2 d=00000056a",
                     OUT_VALID, OUT_PARITY, OUT_COUNT, OUT_DATA);
        end
    endtask

    task automatic test_back_to_back();
        int words = 0;
        do_reset();
        OUT_READY = 1'b1;
        for (int i = 0; i < 14; i++) begin
            IN_VALID = (i < 12);
            IN_DATA  = 6'h01;
            IN_LAST  = 1'b0;
            if (i < 12) begin
                checks++;
                if (IN_READY !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready[%0d]: got %b required 1", i, IN_READY);
                end
            end
            if (OUT_VALID === 1'b1) begin
                words++;
                checks++;
                if ({OUT_PARITY, OUT_COUNT, OUT_DATA} !== {1'b0, 3'd6, 36'h041041041}) begin
                    errors++;
                    $display("FAIL b2b_word[%0d]: got p=%b c=%0d d=%h required p=0 c=6 d=041041041",
                             i, OUT_PARITY, OUT_COUNT, OUT_DATA);
                end
            end
            cycle();
        end
        IN_VALID = 1'b0;
        checks++;
        if (words !== 2 || WORD_CNT !== 16'd2) begin
            errors++;
            $display("FAIL b2b_count: got words=%0d w=%0d required words=2 w=2", words, WORD_CNT);
        end
    endtask

    task automatic test_reset_mid_word();
        do_reset();
        OUT_READY = 1'b1;
        for (int k = 0; k < 4; k++) send(6'h3F, 1'b0);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({OUT_VALID, OUT_PARITY, OUT_COUNT, OUT_DATA, WORD_CNT} !== 57'd0) begin
            errors++;
            $display("FAIL midrst_outputs: got v=%b p=%b c=%0d d=%h w=%h required all 0",
                     OUT_VALID, OUT_PARITY, OUT_COUNT, OUT_DATA, WORD_CNT);
        end
        cycle();
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) send(6'h00, 1'b0);
        checks++;
        if ({OUT_VALID, OUT_PARITY, OUT_COUNT, OUT_DATA} !== {1'b1, 1'b0, 3'd6, 36'h0}) begin
            errors++;
            $display("FAIL midrst_word: got v=%b p=%b c=%0d d=%h required v=1 p=0 c=6 d=0",
                     OUT_VALID, OUT_PARITY, OUT_COUNT, OUT_DATA);
        end
        cycle();
        checks++;
        if (WORD_CNT !== 16'd1) begin
            errors++;
            $display("FAIL midrst_cnt: got %0d required 1", WORD_CNT);
        end
    endtask

    task automatic test_word_cnt_wrap();
        do_reset();
        OUT_READY = 1'b1;
        IN_VALID  = 1'b1;
        IN_LAST   = 1'b1;
        IN_DATA   = 6'h00;
        repeat (100) cycle();
        checks++;
        if ({OUT_VALID, IN_READY, WORD_CNT} !== {1'b1, 1'b1, 16'd99}) begin
            errors++;
            $display("FAIL wrap_stream: got v=%b rdy=%b w=%0d required v=1 rdy=1 w=99",
                     OUT_VALID, IN_READY, WORD_CNT);
        end
        repeat (65435) cycle();
        IN_VALID = 1'b0;
        repeat (2) cycle();
        checks++;
        if (WORD_CNT !== 16'hFFFF) begin
            errors++;
            $display("FAIL wrap_max: got %h required ffff", WORD_CNT);
        end
        send(6'h00, 1'b1);
        cycle();
        checks++;
        if (WORD_CNT !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_zero: got %h required 0000", WORD_CNT);
        end
        IN_LAST = 1'b0;
    endtask

    task automatic test_random();
        logic [5:0]  part[$];
        word_s       exp_q[$];
        word_s       e;
        int unsigned model_cnt = 0;
        logic        acc;
        logic        hand;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n < 2800) begin
                IN_VALID  = ($urandom_range(0, 3) != 0);
                IN_DATA   = 6'($urandom);
                IN_LAST   = ($urandom_range(0, 4) == 0);
                OUT_READY = ($urandom_range(0, 2) != 0);
            end else begin
                IN_VALID  = 1'b0;
                IN_LAST   = 1'b0;
                OUT_READY = 1'b1;
            end
            #1;
            checks++;
            if (OUT_VALID !== (exp_q.size() != 0) ||
                IN_READY !== (exp_q.size() == 0 || OUT_READY)) begin
                errors++;
                $display("FAIL rnd_flags[%0d]: got v=%b rdy=%b required v=%b rdy=%b", n,
                         OUT_VALID, IN_READY, exp_q.size() != 0, exp_q.size() == 0 || OUT_READY);
            end
            checks++;
            if (WORD_CNT !== 16'(model_cnt)) begin
                errors++;
                $display("FAIL rnd_cnt[%0d]: got %0d required %0d", n, WORD_CNT, 16'(model_cnt));
            end
            if (exp_q.size() != 0) begin
                checks++;
                if ({OUT_PARITY, OUT_COUNT, OUT_DATA} !== {exp_q[0].par, exp_q[0].cnt, exp_q[0].data}) begin
                    errors++;
                    $display("FAIL rnd_word[%0d]: got p=%b c=%0d d=%h required p=%b c=%0d d=%h", n,
                             OUT_PARITY, OUT_COUNT, OUT_DATA, exp_q[0].par, exp_q[0].cnt, exp_q[0].data);
                end
            end
            hand = (exp_q.size() != 0) && OUT_READY;
            acc  = IN_VALID && ((exp_q.size() == 0) || OUT_READY);
            if (hand) begin
                void'(exp_q.pop_front());
                model_cnt++;
            end
            if (acc) begin
                part.push_back(IN_DATA);
                if (part.size() == 6 || IN_LAST) begin
                    e.data = '0;
                    foreach (part[k]) e.data = e.data | (36'(part[k]) << (6 * k));
                    e.par = ^e.data;
                    e.cnt = 3'(part.size());
                    exp_q.push_back(e);
                    part.delete();
                end
            end
            cycle();
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_full_word();
        test_partial_flush();
        test_single_chunk();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        test_word_cnt_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
